// File: rtl/piece_randomizer.sv
// Turns the controller LFSR bit stream into tetromino IDs 0..6 with optional 7-bag dealing.
// One registered piece is offered at a time on a valid/ready handshake.
//
// state   | meaning
// --------+---------------------------------------------------------------
// S_FILL  | shift three rand_bit samples into cand, MSB first
// S_CHECK | accept cand, reject it, or force the lowest free ID
// S_HOLD  | piece_id/bag_left presented with piece_valid=1 until piece_ready
module piece_randomizer #(
    parameter bit          BAG_MODE   = 1'b1,
    parameter int unsigned MAX_REJECT = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rand_bit,
    input  logic       piece_ready,
    output logic       piece_valid,
    output logic [2:0] piece_id,
    output logic [2:0] bag_left
);

    localparam int REJ_W = (MAX_REJECT > 1) ? $clog2(MAX_REJECT) : 1;

    typedef enum logic [1:0] {
        S_FILL,
        S_CHECK,
        S_HOLD
    } state_t;

    state_t           state;
    logic [1:0]       bit_cnt;
    logic [2:0]       cand;
    logic [REJ_W-1:0] rej_cnt;
    logic [6:0]       used;

    logic [7:0]       used_ext;
    logic             cand_ok;
    logic             rej_last;
    logic [2:0]       free_id;
    logic [2:0]       pick_id;
    logic [6:0]       pick_mask;
    logic [6:0]       used_next;
    logic             bag_done;

    // ID 7 is treated as permanently dealt so the bag test never indexes past used[6]
    assign used_ext  = {1'b1, used};
    assign cand_ok   = (cand != 3'd7) && (!BAG_MODE || !used_ext[cand]);
    assign rej_last  = (rej_cnt == REJ_W'(MAX_REJECT - 1));
    assign pick_id   = cand_ok ? cand : free_id;
    assign pick_mask = 7'b1 << pick_id;
    assign used_next = used | pick_mask;
    assign bag_done  = (used_next == 7'h7F);

    // Lowest undealt ID; always 0 in uniform mode because used stays clear
    always_comb begin
        free_id = 3'd0;
        for (int i = 6; i >= 0; i--) begin
            if (!used[i]) begin
                free_id = 3'(i);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_FILL;
            bit_cnt     <= 2'd0;
            cand        <= 3'd0;
            rej_cnt     <= '0;
            used        <= 7'b0;
            piece_valid <= 1'b0;
            piece_id    <= 3'd0;
            bag_left    <= 3'd7;
        end else begin
            case (state)
                S_FILL: begin
                    cand    <= {cand[1:0], rand_bit};
                    bit_cnt <= bit_cnt + 2'd1;
                    if (bit_cnt == 2'd2) begin
                        state <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    if (cand_ok || rej_last) begin
                        piece_id    <= pick_id;
                        piece_valid <= 1'b1;
                        rej_cnt     <= '0;
                        state       <= S_HOLD;
                        if (BAG_MODE) begin
                            if (bag_done) begin
                                used     <= 7'b0;
                                bag_left <= 3'd7;
                            end else begin
                                used     <= used_next;
                                bag_left <= bag_left - 3'd1;
                            end
                        end
                    end else begin
                        rej_cnt <= rej_cnt + REJ_W'(1);
                        bit_cnt <= 2'd0;
                        state   <= S_FILL;
                    end
                end
                S_HOLD: begin
                    if (piece_ready) begin
                        piece_valid <= 1'b0;
                        bit_cnt     <= 2'd0;
                        state       <= S_FILL;
                    end
                end
                default: begin
                    state <= S_FILL;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_piece_randomizer.sv
// Directed and randomized deals on a 7-bag instance and a uniform instance,
// checked against a set-based model of the dealing rules.
module tb_piece_randomizer;

    logic       clk = 1'b0;
    logic       reset_b, reset_u;
    logic       rand_bit;
    logic       ready_b, ready_u;
    logic       valid_b, valid_u;
    logic [2:0] id_b, id_u;
    logic [2:0] left_b, left_u;

    always #5 clk = ~clk;

    piece_randomizer #(.BAG_MODE(1'b1), .MAX_REJECT(4)) dut_bag (
        .clk(clk), .reset(reset_b), .rand_bit(rand_bit), .piece_ready(ready_b),
        .piece_valid(valid_b), .piece_id(id_b), .bag_left(left_b)
    );

    piece_randomizer #(.BAG_MODE(1'b0), .MAX_REJECT(8)) dut_uni (
        .clk(clk), .reset(reset_u), .rand_bit(rand_bit), .piece_ready(ready_u),
        .piece_valid(valid_u), .piece_id(id_u), .bag_left(left_u)
    );

    bit sel_uni;
    bit bag;
    int maxr;
    bit dealt [7];
    int q [$];
    int passed = 0;
    int total  = 0;
    int got;

    function automatic logic [7:0] cur_valid();
        return sel_uni ? {7'd0, valid_u} : {7'd0, valid_b};
    endfunction
    function automatic logic [7:0] cur_id();
        return sel_uni ? {5'd0, id_u} : {5'd0, id_b};
    endfunction
    function automatic logic [7:0] cur_left();
        return sel_uni ? {5'd0, left_u} : {5'd0, left_b};
    endfunction

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ready(input logic v);
        if (sel_uni) ready_u = v;
        else ready_b = v;
    endtask

    task automatic set_reset(input logic v);
        if (sel_uni) reset_u = v;
        else reset_b = v;
    endtask

    function automatic int undealt_count();
        int n = 0;
        for (int i = 0; i < 7; i++) if (!dealt[i]) n++;
        return n;
    endfunction

    task automatic do_reset();
        set_reset(1'b1);
        set_ready(1'b1);
        rand_bit = 1'b1;
        step();
        check("rst_valid", cur_valid(), 8'd0);
        check("rst_id", cur_id(), 8'd0);
        check("rst_left", cur_left(), 8'd7);
        set_reset(1'b0);
        set_ready(1'b0);
        for (int i = 0; i < 7; i++) dealt[i] = 1'b0;
    endtask

    // One complete deal: candidates from q (else random), then HOLD for hold_n cycles (-1 = random)
    task automatic deal(input int hold_n, output int exp_id);
        int  rej = 0;
        bit  done = 0;
        bit  ok;
        int  v;
        int  n;
        int  exp_left;
        exp_id = 0;
        while (!done) begin
            v = (q.size() > 0) ? q.pop_front() : int'($urandom_range(0, 7));
            for (int k = 2; k >= 0; k--) begin
                rand_bit = 1'((v >> k) & 1);
                set_ready(1'($urandom_range(0, 1)));
                step();
            end
            rand_bit = 1'($urandom_range(0, 1));
            set_ready(1'($urandom_range(0, 1)));
            step();
            ok = (v != 7) && (!bag || !dealt[v]);
            if (ok) begin
                exp_id = v;
            end else if (rej == maxr - 1) begin
                ok = 1;
                exp_id = 0;
                if (bag) begin
                    for (int i = 6; i >= 0; i--) if (!dealt[i]) exp_id = i;
                end
            end else begin
                rej++;
            end
            check("valid_after_check", cur_valid(), {7'd0, ok});
            done = ok;
        end
        check("piece_id", cur_id(), 8'(exp_id));
        if (bag) begin
            dealt[exp_id] = 1'b1;
            if (undealt_count() == 0) for (int i = 0; i < 7; i++) dealt[i] = 1'b0;
        end
        exp_left = bag ? undealt_count() : 7;
        check("bag_left", cur_left(), 8'(exp_left));
        n = (hold_n < 0) ? int'($urandom_range(0, 3)) : hold_n;
        for (int c = 0; c < n; c++) begin
            set_ready(1'b0);
            rand_bit = 1'($urandom_range(0, 1));
            step();
            check("hold_valid", cur_valid(), 8'd1);
            check("hold_id", cur_id(), 8'(exp_id));
            check("hold_left", cur_left(), 8'(exp_left));
        end
        set_ready(1'b1);
        step();
        check("accept_valid", cur_valid(), 8'd0);
        set_ready(1'b0);
    endtask

    initial begin
        reset_b  = 1'b1;
        reset_u  = 1'b1;
        ready_b  = 1'b0;
        ready_u  = 1'b0;
        rand_bit = 1'b0;

        sel_uni = 1'b0;
        bag     = 1'b1;
        maxr    = 4;
        do_reset();
        q = '{5};       deal(0, got);
        q = '{7, 2};    deal(1, got);

        do_reset();
        q = '{3};       deal(0, got);
        q = '{3, 4};    deal(0, got);

        do_reset();
        q = '{0};          deal(0, got);
        q = '{1};          deal(0, got);
        q = '{7, 7, 7, 7}; deal(0, got);
        q = '{3};          deal(0, got);
        q = '{4};          deal(0, got);
        q = '{5};          deal(0, got);
        q = '{6};          deal(0, got);
        deal(-1, got);
        deal(10, got);

        rand_bit = 1'b1;
        step();
        reset_b = 1'b1;
        step();
        check("midfill_rst_valid", {7'd0, valid_b}, 8'd0);
        check("midfill_rst_left", {5'd0, left_b}, 8'd7);
        reset_b = 1'b0;
        for (int i = 0; i < 7; i++) dealt[i] = 1'b0;
        for (int d = 0; d < 40; d++) deal(-1, got);

        reset_b = 1'b1;
        sel_uni = 1'b1;
        bag     = 1'b0;
        maxr    = 8;
        do_reset();
        q = '{7, 7, 7, 7, 7, 7, 7, 7}; deal(0, got);
        q = '{6};                      deal(0, got);
        q = '{6};                      deal(0, got);
        for (int d = 0; d < 25; d++) deal(-1, got);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
